lsu_mem_ctrl: RTL

- Multi-cycle data-memory controller downstream of the core's load/store path. Replaces the single-cycle combinational RAM port.
- Accepts one load/store request per transaction over a valid/ready handshake.
- Drives a word-addressed, byte-masked SRAM port with fixed read latency.
- Returns aligned, sign/zero-extended load data or an error flag to the core over a second valid/ready handshake.

---
 rtl/lsu_mem_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - multi-cycle load/store controller driving a fixed-latency byte-masked SRAM
module lsu_mem_ctrl #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [1:0]       off_q;
    logic [2:0]       f3_q;

    assign req_ready = (state == IDLE) && !rst;

    function automatic logic is_legal(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = !off[0];
            3'b010:  ok = (off == 2'b00);
            3'b100:  ok = !we;
            3'b101:  ok = !we && !off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            3'b010:  r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            off_q      <= 2'b00;
            f3_q       <= 3'b000;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_wmask  <= 4'd0;
        end else begin
            // SRAM strobe and its qualifiers live for exactly one cycle after the accept edge
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_wmask <= 4'd0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q  <= req_we;
                        off_q <= req_addr[1:0];
                        f3_q  <= req_funct3;
                        if (!is_legal(req_we, req_funct3, req_addr[1:0])) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
                            state     <= ACCESS;
                            cnt       <= CNT_W'(LATENCY);
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= req_we ? store_data(req_funct3[1:0], req_wdata) : 32'd0;
                            mem_wmask <= req_we ? store_mask(req_funct3[1:0], req_addr[1:0]) : 4'd0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == CNT_W'(1)) begin
                        cnt        <= '0;
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= we_q ? 32'd0 : load_extract(f3_q, off_q, mem_rdata);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= 32'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
